// File: rtl/stq_pkg.sv
// stq_pkg: shared store-queue sizing constants and pointer type
package stq_pkg;
    localparam int STQ_ENTRIES = 32;
    localparam int STQ_PTR_W = 6;
    typedef logic [STQ_PTR_W-1:0] stq_ptr_t;
endpackage

// File: rtl/stq_onehot_dec.sv
// stq_onehot_dec: entry index to one-hot enable vector, gated by en
module stq_onehot_dec #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot
);
    always_comb onehot = en ? (N'(1) << idx) : '0;
endmodule

// File: rtl/stq_ctrl_l.sv
// stq_ctrl_l: store-queue pointer control (allocate, commit, release, flush)
module stq_ctrl_l
    import stq_pkg::*;
#(
    parameter int BUF_COUNT = STQ_ENTRIES,
    localparam int IW = $clog2(BUF_COUNT),
    localparam int PW = IW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc0_req,
    input  logic                 alloc1_req,
    input  logic [1:0]           retire_cnt,
    input  logic                 free_req,
    input  logic                 excpt,
    output logic [BUF_COUNT-1:0] wrt0_en,
    output logic [BUF_COUNT-1:0] wrt1_en,
    output logic [IW-1:0]        alloc0_idx,
    output logic [IW-1:0]        alloc1_idx,
    output logic [BUF_COUNT-1:0] passe_en,
    output logic [BUF_COUNT-1:0] free_en,
    output logic                 alloc_stall,
    output logic                 empty,
    output logic                 full,
    output logic [PW-1:0]        count
);
    logic [PW-1:0] head, ret, tail, pend, ret_n, ret1, tail_a1;
    logic [1:0] rc, n;
    logic grant, do_free;
    logic [BUF_COUNT-1:0] passe_a, passe_b;
    // All decisions use the registered pointers; updates land next cycle
    always_comb begin
        count = tail - head;
        empty = count == '0;
        full = count == PW'(BUF_COUNT);
        alloc_stall = count >= PW'(BUF_COUNT - 1);
        grant = !alloc_stall && !excpt && !rst;
        tail_a1 = tail + PW'(alloc0_req);
        alloc0_idx = tail[IW-1:0];
        alloc1_idx = tail_a1[IW-1:0];
        pend = tail - ret;
        rc = retire_cnt > 2'd2 ? 2'd2 : retire_cnt;
        n = PW'(rc) > pend ? pend[1:0] : rc;
        ret_n = ret + PW'(n);
        ret1 = ret + PW'(1);
        do_free = free_req && head != ret && !rst;
    end
    assign passe_en = passe_a | passe_b;
    stq_onehot_dec #(.N(BUF_COUNT)) u_wrt0 (.idx(tail[IW-1:0]), .en(grant && alloc0_req), .onehot(wrt0_en));
    stq_onehot_dec #(.N(BUF_COUNT)) u_wrt1 (.idx(tail_a1[IW-1:0]), .en(grant && alloc1_req), .onehot(wrt1_en));
    stq_onehot_dec #(.N(BUF_COUNT)) u_passe0 (.idx(ret[IW-1:0]), .en(!rst && n != 2'd0), .onehot(passe_a));
    stq_onehot_dec #(.N(BUF_COUNT)) u_passe1 (.idx(ret1[IW-1:0]), .en(!rst && n == 2'd2), .onehot(passe_b));
    stq_onehot_dec #(.N(BUF_COUNT)) u_free (.idx(head[IW-1:0]), .en(do_free), .onehot(free_en));
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            ret <= '0;
            tail <= '0;
        end else begin
            head <= head + PW'(do_free);
            ret <= ret_n;
            tail <= excpt ? ret_n : tail + (grant ? PW'(alloc0_req) + PW'(alloc1_req) : '0);
        end
    end
endmodule

// File: tb/tb_stq_ctrl_l.sv
// tb_stq_ctrl_l: directed checks of allocation, wrap, retire clipping, flush, free and reset
module tb_stq_ctrl_l;
    import stq_pkg::*;
    logic clk = 0, rst, alloc0_req, alloc1_req, free_req, excpt;
    logic [1:0] retire_cnt;
    logic [31:0] wrt0_en, wrt1_en, passe_en, free_en;
    logic [4:0] alloc0_idx, alloc1_idx;
    logic alloc_stall, empty, full;
    logic [5:0] count;
    int checks = 0, errors = 0;

    stq_ctrl_l #(.BUF_COUNT(32)) dut (
        .clk(clk), .rst(rst), .alloc0_req(alloc0_req), .alloc1_req(alloc1_req),
        .retire_cnt(retire_cnt), .free_req(free_req), .excpt(excpt),
        .wrt0_en(wrt0_en), .wrt1_en(wrt1_en), .alloc0_idx(alloc0_idx), .alloc1_idx(alloc1_idx),
        .passe_en(passe_en), .free_en(free_en), .alloc_stall(alloc_stall),
        .empty(empty), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        alloc0_req = 0; alloc1_req = 0; retire_cnt = 0; free_req = 0; excpt = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 1; idle(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; alloc0_req = 1; alloc1_req = 1; excpt = 1; free_req = 1; retire_cnt = 2;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (wrt0_en !== 0 || wrt1_en !== 0) begin errors++; $display("FAIL reset_wrt: got %h/%h expected 0/0", wrt0_en, wrt1_en); end
        checks++; if (passe_en !== 0 || free_en !== 0) begin errors++; $display("FAIL reset_passe_free: got %h/%h expected 0/0", passe_en, free_en); end
        checks++; if (count !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if ({empty, full, alloc_stall} !== 3'b100) begin errors++; $display("FAIL reset_flags: got %b expected 100", {empty, full, alloc_stall}); end
        @(posedge clk); #1;
        rst = 0; idle();
    endtask

    task automatic test_dual_alloc();
        logic [31:0] e0, e1;
        for (int k = 0; k < 3; k++) begin
            alloc0_req = 1; alloc1_req = 1;
            @(negedge clk);
            e0 = 32'd1 << (2 * k); e1 = 32'd1 << (2 * k + 1);
            checks++; if (wrt0_en !== e0) begin errors++; $display("FAIL dual_wrt0_%0d: got %h expected %h", k, wrt0_en, e0); end
            checks++; if (wrt1_en !== e1) begin errors++; $display("FAIL dual_wrt1_%0d: got %h expected %h", k, wrt1_en, e1); end
            checks++; if (alloc1_idx !== 5'(2 * k + 1)) begin errors++; $display("FAIL dual_idx1_%0d: got %0d expected %0d", k, alloc1_idx, 2 * k + 1); end
            tick();
        end
        checks++; if (count !== 6) begin errors++; $display("FAIL dual_count: got %0d expected 6", count); end
    endtask

    task automatic test_full();
        for (int k = 0; k < 12; k++) begin alloc0_req = 1; alloc1_req = 1; tick(); end
        checks++; if (count !== 30 || alloc_stall !== 0) begin errors++; $display("FAIL full_pre: got count %0d stall %b expected 30 0", count, alloc_stall); end
        alloc0_req = 1; alloc1_req = 1;
        @(negedge clk);
        checks++; if (wrt0_en !== 32'h4000_0000 || wrt1_en !== 32'h8000_0000) begin errors++; $display("FAIL full_last_wrt: got %h/%h expected 40000000/80000000", wrt0_en, wrt1_en); end
        tick();
        checks++; if ({full, alloc_stall} !== 2'b11 || count !== 32) begin errors++; $display("FAIL full_flags: got full %b stall %b count %0d expected 1 1 32", full, alloc_stall, count); end
        alloc0_req = 1; alloc1_req = 1;
        @(negedge clk);
        checks++; if (wrt0_en !== 0 || wrt1_en !== 0) begin errors++; $display("FAIL full_stall_wrt: got %h/%h expected 0/0", wrt0_en, wrt1_en); end
        tick();
        checks++; if (dut.tail !== stq_ptr_t'(32) || count !== 32) begin errors++; $display("FAIL full_tail_hold: got tail %0d count %0d expected 32 32", dut.tail, count); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 15; k++) begin alloc0_req = 1; alloc1_req = 1; tick(); end
        alloc0_req = 1; tick();
        for (int k = 0; k < 10; k++) begin retire_cnt = 2; tick(); end
        for (int k = 0; k < 20; k++) begin free_req = 1; tick(); end
        checks++; if (count !== 11 || dut.tail !== stq_ptr_t'(31)) begin errors++; $display("FAIL wrap_pre: got count %0d tail %0d expected 11 31", count, dut.tail); end
        alloc0_req = 1; alloc1_req = 1;
        @(negedge clk);
        checks++; if (wrt0_en !== 32'h8000_0000 || wrt1_en !== 32'h1) begin errors++; $display("FAIL wrap_wrt: got %h/%h expected 80000000/00000001", wrt0_en, wrt1_en); end
        checks++; if (alloc1_idx !== 5'd0) begin errors++; $display("FAIL wrap_idx1: got %0d expected 0", alloc1_idx); end
        tick();
        checks++; if (dut.tail !== stq_ptr_t'(33) || count !== 13) begin errors++; $display("FAIL wrap_tail: got tail %0d count %0d expected 33 13", dut.tail, count); end
        alloc1_req = 1;
        @(negedge clk);
        checks++; if (wrt0_en !== 0 || wrt1_en !== 32'h2) begin errors++; $display("FAIL lone_alloc1: got %h/%h expected 0/00000002", wrt0_en, wrt1_en); end
        tick();
        checks++; if (dut.tail !== stq_ptr_t'(34)) begin errors++; $display("FAIL lone_alloc1_tail: got %0d expected 34", dut.tail); end
    endtask

    task automatic test_retire_clip();
        do_reset();
        alloc0_req = 1; alloc1_req = 1; tick();
        alloc0_req = 1; tick();
        retire_cnt = 2;
        @(negedge clk);
        checks++; if (passe_en !== 32'h3) begin errors++; $display("FAIL retire_two: got %h expected 00000003", passe_en); end
        tick();
        retire_cnt = 2;
        @(negedge clk);
        checks++; if (passe_en !== 32'h4) begin errors++; $display("FAIL retire_clip: got %h expected 00000004", passe_en); end
        tick();
        checks++; if (dut.ret !== stq_ptr_t'(3)) begin errors++; $display("FAIL retire_clip_ret: got %0d expected 3", dut.ret); end
        retire_cnt = 1;
        @(negedge clk);
        checks++; if (passe_en !== 0) begin errors++; $display("FAIL retire_none: got %h expected 0", passe_en); end
        tick();
        checks++; if (dut.ret !== stq_ptr_t'(3)) begin errors++; $display("FAIL retire_none_ret: got %0d expected 3", dut.ret); end
    endtask

    task automatic test_excpt();
        do_reset();
        for (int k = 0; k < 3; k++) begin alloc0_req = 1; alloc1_req = 1; tick(); end
        retire_cnt = 2; tick();
        excpt = 1; alloc0_req = 1; retire_cnt = 1;
        @(negedge clk);
        checks++; if (passe_en !== 32'h4) begin errors++; $display("FAIL excpt_passe: got %h expected 00000004", passe_en); end
        checks++; if (wrt0_en !== 0 || wrt1_en !== 0) begin errors++; $display("FAIL excpt_wrt: got %h/%h expected 0/0", wrt0_en, wrt1_en); end
        tick();
        checks++; if (dut.tail !== stq_ptr_t'(3) || count !== 3) begin errors++; $display("FAIL excpt_tail: got tail %0d count %0d expected 3 3", dut.tail, count); end
    endtask

    task automatic test_free_rst();
        logic [31:0] e;
        for (int k = 0; k < 3; k++) begin
            free_req = 1;
            @(negedge clk);
            e = 32'd1 << k;
            checks++; if (free_en !== e) begin errors++; $display("FAIL free_%0d: got %h expected %h", k, free_en, e); end
            tick();
        end
        free_req = 1;
        @(negedge clk);
        checks++; if (free_en !== 0) begin errors++; $display("FAIL free_ignored: got %h expected 0", free_en); end
        tick();
        checks++; if (dut.head !== stq_ptr_t'(3) || empty !== 1) begin errors++; $display("FAIL free_ignored_head: got head %0d empty %b expected 3 1", dut.head, empty); end
        for (int k = 0; k < 2; k++) begin alloc0_req = 1; alloc1_req = 1; retire_cnt = 1; tick(); end
        rst = 1; alloc0_req = 1; alloc1_req = 1; excpt = 1; free_req = 1; retire_cnt = 2;
        @(negedge clk);
        checks++; if (wrt0_en !== 0 || wrt1_en !== 0 || passe_en !== 0 || free_en !== 0) begin errors++; $display("FAIL midrst_enables: got %h/%h/%h/%h expected all 0", wrt0_en, wrt1_en, passe_en, free_en); end
        @(posedge clk); #1;
        rst = 0; idle();
        checks++; if (dut.head !== 0 || dut.ret !== 0 || dut.tail !== 0 || empty !== 1) begin errors++; $display("FAIL midrst_ptrs: got %0d/%0d/%0d empty %b expected 0/0/0 1", dut.head, dut.ret, dut.tail, empty); end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_dual_alloc();
        test_full();
        test_wrap();
        test_retire_clip();
        test_excpt();
        test_free_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stq_ctrl_l.md
STQ_CTRL_L -- requirements
Module: stq_ctrl_L

Interface
REQ-001 SHALL have parameter BUF_COUNT, default 32, meaning the number of store-queue entries; it SHALL be a power of two.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port alloc0_req / alloc1_req, input, 1 bit each: request to allocate a new store in slot 0 / slot 1.
REQ-005 SHALL have port retire_cnt, input, 2 bits: number of stores committed this cycle (0..2).
REQ-006 SHALL have port free_req, input, 1 bit: the cache write of the oldest committed store is done.
REQ-007 SHALL have port excpt, input, 1 bit: flush all uncommitted stores.
REQ-008 SHALL have port wrt0_en / wrt1_en, output, BUF_COUNT bits each: one-hot entry write enables.
REQ-009 SHALL have port alloc0_idx / alloc1_idx, output, 5 bits each: the allocated entry index.
REQ-010 SHALL have port passe_en / free_en, output, BUF_COUNT bits each: entry commit / entry release enables.
REQ-011 SHALL have port alloc_stall, output, 1 bit: fewer than 2 entries are free.
REQ-012 SHALL have ports empty and full, output, 1 bit each; and count, output, 6 bits: occupied entries.

Function
REQ-013 SHALL hold three registered 6-bit pointers (index plus wrap bit): head (oldest unfreed entry), ret (oldest uncommitted entry) and tail (next entry to allocate), with ordering head <= ret <= tail modulo wrap.
REQ-014 SHALL compute count = tail - head (6 bits), empty = (count == 0) and full = (count == BUF_COUNT), all from registered pointers only.
REQ-015 SHALL assert alloc_stall when BUF_COUNT - count < 2; while alloc_stall is asserted, wrt0_en and wrt1_en SHALL be zero and tail SHALL NOT advance.
REQ-016 SHALL, when granted, make wrt0_en the one-hot of tail[4:0] if alloc0_req is set, and make wrt1_en the one-hot of (tail + alloc0_req)[4:0] if alloc1_req is set; the enables are combinational in the same cycle.
REQ-017 SHALL advance tail by alloc0_req + alloc1_req when granted; a lone alloc1_req SHALL use entry tail.
REQ-018 SHALL set passe_en bits for min(retire_cnt, tail - ret) consecutive entries starting at ret, and advance ret by the same amount; any excess retire_cnt SHALL be clipped silently.
REQ-019 SHALL, on free_req with head != ret, set free_en to the one-hot of head[4:0] and increment head; free_req with head == ret SHALL be ignored.
REQ-020 SHALL, on excpt, force wrt0_en and wrt1_en to zero, discard that cycle's allocation, and set tail to the post-retire ret value; retire and free SHALL still be processed that cycle.
REQ-021 SHALL use pre-update pointers for all same-cycle decisions: a free SHALL NOT relieve alloc_stall until the next cycle.
REQ-022 SHALL let pointers wrap from BUF_COUNT-1 to 0, toggling the wrap bit.

Reset
REQ-023 SHALL, while rst is high, set head = ret = tail = 0 and drive every enable output to zero; count SHALL be 0, empty 1, full 0, alloc_stall 0.
REQ-024 SHALL let rst override excpt and all requests in the same cycle, including mid-operation.

Structure
REQ-025 SHALL place STQ_ENTRIES=32, STQ_PTR_W=6 and the pointer typedef in the shared package stq_pkg.
REQ-026 SHALL instantiate a single sub-module, stq_onehot_dec (pointer to BUF_COUNT one-hot with enable), for every enable vector.

Verification
REQ-027 The bench SHALL cover: after reset, alloc0 and alloc1 both requested for 3 cycles -> wrt0_en = bits 0, 2, 4 and wrt1_en = bits 1, 3, 5; count = 6.
REQ-028 The bench SHALL cover: with count = 30, a dual alloc -> full = 1 and alloc_stall = 1; a further dual alloc -> no enables and tail unchanged.
REQ-029 The bench SHALL cover: with tail = 31 and head = 20, a dual alloc -> wrt0_en bit 31, wrt1_en bit 0, and the tail wrap bit toggles.
REQ-030 The bench SHALL cover: with ret = 2 and tail = 3, retire_cnt = 2 -> only passe_en bit 2 is set and ret = 3.
REQ-031 The bench SHALL cover: with head = 0, ret = 2 and tail = 6, excpt together with alloc0_req and retire_cnt = 1 -> passe_en bit 2, no wrt enable, tail = 3 and count = 3 next cycle.
REQ-032 The bench SHALL cover: free_req with head == ret -> free_en = 0; rst asserted mid-stream -> all pointers 0 and empty = 1 in the next cycle.
